// File: rtl/fan_pkg.sv
// Shared fan definitions used by the fan controller and the fan PWM driver.
package fan_pkg;

   localparam int FAN_MAX_SPEED       = 8;
   localparam int PWM_SLOTS           = 16;
   localparam int SLOT_W              = 4;
   localparam int DUTY_W              = 5;
   localparam int FAN_STALL_MIN_SPEED = 2;

   typedef logic [3:0]        fan_speed_t;
   typedef logic [DUTY_W-1:0] fan_duty_t;

   // Commands above full speed mean full speed.
   function automatic fan_speed_t clamp_speed(input fan_speed_t crs);
      return (crs > fan_speed_t'(FAN_MAX_SPEED)) ? fan_speed_t'(FAN_MAX_SPEED) : crs;
   endfunction

endpackage

// File: rtl/fan_pwm_driver_if.sv
// Command/status bundle between the fan controller (master) and the PWM driver (slave).
interface fan_pwm_driver_if;
   import fan_pkg::*;

   logic       Cooler;
   fan_speed_t CRS;
   logic       pwm;
   fan_speed_t cur_speed;
   logic       at_target;
   logic       stall;

   modport master (output Cooler, CRS, input pwm, cur_speed, at_target, stall);
   modport slave  (input Cooler, CRS, output pwm, cur_speed, at_target, stall);

endinterface

// File: rtl/fan_tach_monitor.sv
// Tach synchroniser, rising-edge counter and per-window sticky stall alarm.
module fan_tach_monitor
   import fan_pkg::*;
#(
   parameter int STALL_PERIODS = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic tach,
   input  logic period_end,
   input  logic armed,
   output logic stall
);
   localparam int WW = (STALL_PERIODS > 1) ? $clog2(STALL_PERIODS) : 1;
   localparam logic [WW-1:0] WIN_LAST = WW'(STALL_PERIODS - 1);

   // [0],[1] synchronise the pin, [2] holds the previous synchronised level.
   logic [2:0]    tach_sync_reg;
   logic [3:0]    tach_cnt_reg;
   logic [WW-1:0] win_reg;
   logic          stall_reg;
   logic          tach_rise;
   logic          win_end;

   assign tach_rise = tach_sync_reg[1] & ~tach_sync_reg[2];
   assign win_end   = period_end && (win_reg == WIN_LAST);
   assign stall     = stall_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         tach_sync_reg <= '0;
         tach_cnt_reg  <= '0;
         win_reg       <= '0;
         stall_reg     <= 1'b0;
      end else begin
         tach_sync_reg <= {tach_sync_reg[1:0], tach};
         if (clr || !armed) begin
            win_reg      <= '0;
            tach_cnt_reg <= '0;
         end else begin
            if (tach_rise && (tach_cnt_reg != '1))
               tach_cnt_reg <= tach_cnt_reg + 4'd1;
            if (period_end)
               win_reg <= win_reg + WW'(1);
            if (win_end) begin
               win_reg      <= '0;
               tach_cnt_reg <= '0;
               if ((tach_cnt_reg == '0) && !tach_rise)
                  stall_reg <= 1'b1;
            end
         end
         if (clr)
            stall_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/fan_pwm_driver.sv
// Fan motor PWM driver: 16-slot PWM with one-step-per-interval speed slewing.
// Optional tach stall alarm is built when FAN_STALL_DETECT_EN is defined.
module fan_pwm_driver
   import fan_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int RAMP_PERIODS  = 8,
   parameter int STALL_PERIODS = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tach,
   fan_pwm_driver_if.slave bus
);
   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
   localparam logic [PW-1:0]     PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [RW-1:0]     RAMP_LAST  = RW'(RAMP_PERIODS - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(PWM_SLOTS - 1);

   fan_speed_t        tgt_reg;
   fan_speed_t        cur_reg;
   fan_speed_t        cur_next;
   fan_duty_t         duty_reg;
   fan_duty_t         duty_next;
   logic [PW-1:0]     presc_reg;
   logic [SLOT_W-1:0] slot_reg;
   logic [RW-1:0]     ramp_reg;
   logic              slot_tick;
   logic              period_end;
   logic              ramp_wrap;

   assign slot_tick  = (presc_reg == PRESC_LAST);
   assign period_end = slot_tick && (slot_reg == SLOT_LAST);
   assign ramp_wrap  = period_end && (ramp_reg == RAMP_LAST);

   // Duty follows the speed that will hold for the coming period, so a new
   // step shows up in the very first slot after it is taken.
   always_comb begin
      cur_next  = cur_reg;
      duty_next = duty_reg;
      if (!bus.Cooler) begin
         cur_next  = '0;
         duty_next = '0;
      end else begin
         if (ramp_wrap) begin
            if (cur_reg < tgt_reg)
               cur_next = cur_reg + 4'd1;
            else if (cur_reg > tgt_reg)
               cur_next = cur_reg - 4'd1;
         end
         if (period_end)
            duty_next = {cur_next, 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tgt_reg   <= '0;
         cur_reg   <= '0;
         duty_reg  <= '0;
         presc_reg <= '0;
         slot_reg  <= '0;
         ramp_reg  <= '0;
      end else begin
         tgt_reg   <= bus.Cooler ? clamp_speed(bus.CRS) : '0;
         presc_reg <= slot_tick ? '0 : presc_reg + PW'(1);
         if (slot_tick)
            slot_reg <= slot_reg + SLOT_W'(1);
         if (period_end)
            ramp_reg <= ramp_wrap ? '0 : ramp_reg + RW'(1);
         cur_reg   <= cur_next;
         duty_reg  <= duty_next;
      end
   end

   assign bus.pwm       = ({1'b0, slot_reg} < duty_reg);
   assign bus.cur_speed = cur_reg;
   assign bus.at_target = (cur_reg == tgt_reg);

`ifdef FAN_STALL_DETECT_EN
   logic stall_w;

   fan_tach_monitor #(
      .STALL_PERIODS(STALL_PERIODS)
   ) u_tach_monitor (
      .clk        (clk),
      .rst        (rst),
      .clr        (!bus.Cooler),
      .tach       (tach),
      .period_end (period_end),
      .armed      (cur_reg >= fan_speed_t'(FAN_STALL_MIN_SPEED)),
      .stall      (stall_w)
   );

   assign bus.stall = stall_w;
`else
   localparam int unused_stall_periods = STALL_PERIODS;
   logic unused_tach;

   assign unused_tach = tach;
   assign bus.stall   = 1'b0;
`endif

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Randomised scoreboard bench for fan_pwm_driver against a cycle-arithmetic model.
module tb_fan_pwm_driver;
   localparam int CLK_DIV       = 2;
   localparam int RAMP_PERIODS  = 2;
   localparam int STALL_PERIODS = 4;
   localparam int PERIOD        = 16 * CLK_DIV;
   localparam int STEP          = RAMP_PERIODS * PERIOD;
`ifdef FAN_STALL_DETECT_EN
   localparam logic STALL_ON = 1'b1;
`else
   localparam logic STALL_ON = 1'b0;
`endif

   typedef struct {
      int   spd;
      logic at;
      logic pwm;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tach = 1'b0;
   logic tach_run = 1'b0;

   fan_pwm_driver_if bus();

   fan_pwm_driver #(
      .CLK_DIV      (CLK_DIV),
      .RAMP_PERIODS (RAMP_PERIODS),
      .STALL_PERIODS(STALL_PERIODS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .tach(tach),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   // Model state: cycles since reset, applied speed, target, high cycles per period.
   int n_m   = 0;
   int spd_m = 0;
   int tgt_m = 0;
   int hi_m  = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (model cycle %0d)", name, act, req, n_m);
      end
   endtask

   // Reference model: speed steps land on multiples of the step interval,
   // the high time of each period is fixed at its start.
   initial begin
      exp_t e;
      int   old_tgt;
      forever begin
         @(posedge clk);
         if (rst) begin
            n_m = 0; spd_m = 0; tgt_m = 0; hi_m = 0;
         end else begin
            n_m++;
            old_tgt = tgt_m;
            tgt_m = bus.Cooler ? ((int'(bus.CRS) > 8) ? 8 : int'(bus.CRS)) : 0;
            if (!bus.Cooler) begin
               spd_m = 0;
               hi_m  = 0;
            end else begin
               if ((n_m % STEP == 0) && (spd_m != old_tgt))
                  spd_m = (spd_m < old_tgt) ? spd_m + 1 : spd_m - 1;
               if (n_m % PERIOD == 0)
                  hi_m = 2 * spd_m * CLK_DIV;
            end
         end
         e.spd = spd_m;
         e.at  = (spd_m == tgt_m);
         e.pwm = ((n_m % PERIOD) < hi_m);
         sb_q.push_back(e);
      end
   end

   // Monitor: compares every presented output against the queued expectation.
   initial begin
      exp_t e;
      int   last_spd = 0;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("cur_speed", 8'(bus.cur_speed), 8'(e.spd));
            check("at_target", 8'(bus.at_target), 8'(e.at));
            check("pwm", 8'(bus.pwm), 8'(e.pwm));
`ifndef FAN_STALL_DETECT_EN
            check("stall_tied", 8'(bus.stall), 8'(0));
`endif
            if (e.spd != last_spd)
               $display("cycle %0d: speed step %0d -> %0d", n_m, last_spd, e.spd);
            last_spd = e.spd;
         end
      end
   end

   // Tach generator: level toggles every 20 cycles while enabled.
   initial begin
      int tcnt = 0;
      forever begin
         @(negedge clk);
         if (tach_run) begin
            tcnt++;
            if (tcnt >= 20) begin
               tcnt = 0;
               tach = ~tach;
            end
         end
      end
   end

   task automatic cycles(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic wait_speed(input int s, input string name);
      int k = 0;
      while (spd_m != s && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (spd_m != s) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: timeout, model speed %0d, wanted %0d", name, spd_m, s);
      end
   endtask

   task automatic count_pwm(input string name, input int req);
      int hi = 0;
      repeat (PERIOD) begin
         @(negedge clk);
         if (bus.pwm === 1'b1) hi++;
      end
      check(name, 8'(hi), 8'(req));
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bus.Cooler = 1'b0;
      bus.CRS    = 4'd0;
      cycles(4);
      check("reset_cur_speed", 8'(bus.cur_speed), 8'(0));
      check("reset_at_target", 8'(bus.at_target), 8'(1));
      check("reset_pwm", 8'(bus.pwm), 8'(0));
      check("reset_stall", 8'(bus.stall), 8'(0));
      rst = 1'b0;

      // Ramp 0 -> 4, then 50% duty
      bus.Cooler = 1'b1;
      bus.CRS    = 4'd4;
      wait_speed(4, "ramp_to_4");
      cycles(PERIOD + 2);
      count_pwm("duty_speed4", 16);
      $display("txn: ramp to 4 done, model cycle %0d", n_m);

      // Full speed and clamp
      bus.CRS = 4'd8;
      wait_speed(8, "ramp_to_8");
      cycles(PERIOD + 2);
      count_pwm("duty_speed8", PERIOD);
      bus.CRS = 4'd12;
      cycles(100);
      count_pwm("duty_crs12", PERIOD);
      $display("txn: full speed and clamp done, model cycle %0d", n_m);

      // Cooler drop at speed 6
      bus.CRS = 4'd6;
      wait_speed(6, "ramp_to_6");
      cycles(9);
      bus.Cooler = 1'b0;
      cycles(1);
      check("cooler_drop_pwm", 8'(bus.pwm), 8'(0));
      check("cooler_drop_speed", 8'(bus.cur_speed), 8'(0));
      cycles(20);
      $display("txn: cooler drop done, model cycle %0d", n_m);

      // Ramp reversal 0 -> 6 interrupted at 4
      bus.Cooler = 1'b1;
      bus.CRS    = 4'd6;
      wait_speed(4, "reverse_at_4");
      bus.CRS = 4'd2;
      cycles(5 * STEP);
      check("reverse_final", 8'(bus.cur_speed), 8'(2));
      $display("txn: ramp reversal done, model cycle %0d", n_m);

      // Stall: no tach at speed 4, then sticky, then clear via Cooler
      pulse_rst();
      bus.CRS = 4'd4;
      cycles(400);
      check("stall_set", 8'(bus.stall), 8'(STALL_ON));
      tach_run = 1'b1;
      cycles(300);
      check("stall_sticky", 8'(bus.stall), 8'(STALL_ON));
      bus.Cooler = 1'b0;
      cycles(1);
      check("stall_clr_cooler", 8'(bus.stall), 8'(0));
      bus.Cooler = 1'b1;
      pulse_rst();
      cycles(600);
      check("stall_ok_with_tach", 8'(bus.stall), 8'(0));
      $display("txn: stall scenarios done, model cycle %0d", n_m);

      // Reset mid-period at speed 6
      bus.CRS = 4'd6;
      wait_speed(6, "ramp_to_6_rst");
      cycles(7);
      rst = 1'b1;
      cycles(1);
      check("midrst_pwm", 8'(bus.pwm), 8'(0));
      check("midrst_speed", 8'(bus.cur_speed), 8'(0));
      check("midrst_at_target", 8'(bus.at_target), 8'(1));
      check("midrst_stall", 8'(bus.stall), 8'(0));
      rst = 1'b0;
      $display("txn: mid-period reset done, model cycle %0d", n_m);

      // Randomised commands
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 19) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         bus.Cooler = ($urandom_range(0, 9) != 0);
         bus.CRS    = 4'($urandom_range(0, 15));
         tach_run   = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 160)) @(negedge clk);
         $display("txn rand %0d: Cooler=%0b CRS=%0d model speed %0d", i, bus.Cooler, bus.CRS, spd_m);
      end

      cycles(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fan_pwm_driver.md
# fan_pwm_driver

Drives the incubator cooler fan motor from the 4-bit rotation-speed command (CRS) produced by the fan controller. Converts the commanded speed into a 16-slot PWM waveform and slews the applied speed one step at a time toward the command, so the motor never sees a step change. Optionally watches the fan tachometer and flags a stalled fan. Sits between the fan controller and the motor driver pin.

## Interface
Parameters:
- CLK_DIV, default 4: clk cycles per PWM slot (≥2).
- RAMP_PERIODS, default 8: PWM periods between speed steps (≥1).
- STALL_PERIODS, default 64: PWM periods per tach observation window (≥2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- Cooler  in  1  cooler enable; low forces fan off.
- CRS  in  4  commanded speed; 0..8 meaningful, values >8 clamp to 8.
- tach  in  1  asynchronous tach pulse from fan, one rising edge per revolution.
- pwm  out  1  motor drive.
- cur_speed  out  4  speed currently applied, 0..8.
- at_target  out  1  cur_speed equals registered target.
- stall  out  1  sticky stall alarm.

## Operation
- Target register tgt: each cycle tgt <= Cooler ? min(CRS,8) : 0.
- Prescaler counts 0..CLK_DIV-1; slot_tick when at CLK_DIV-1.
- Slot counter 0..15, advances on slot_tick; wraps 15→0; the wrap cycle is period_end.
- duty (5 bits, 0..16) = 2*cur_speed, latched only at period_end; pwm = (slot < duty). Speed 8 gives pwm constantly high; 0 gives constantly low.
- Ramp counter 0..RAMP_PERIODS-1 advances on period_end and runs freely; it is not cleared by a target change. When it wraps and cur_speed ≠ tgt, cur_speed moves exactly 1 toward tgt.
- Cooler low overrides ramping: cur_speed <= 0, duty <= 0, pwm <= 0 on the next edge, with no ramp-down.
- at_target = (cur_speed == tgt), combinational from registers.
- Stall monitor: tach is 2-flop synchronised, then rising edges counted. The window is STALL_PERIODS periods. If cur_speed ≥ 2 during the whole window and the edge count is 0 at window end, stall <= 1. stall clears only on rst or Cooler low. The window restarts whenever cur_speed < 2.

## Timing
- Reset values: pwm 0, cur_speed 0, tgt 0, duty 0, all counters 0, stall 0. at_target is therefore 1.
- CRS → tgt latency: 1 cycle.
- First speed step occurs at the next ramp-counter wrap. Worst case is RAMP_PERIODS·16·CLK_DIV cycles after tgt changes. Each further step follows after exactly that interval.
- New duty appears at the first slot of the next period. pwm is never truncated mid-period except when Cooler goes low.
- rst mid-period: all state returns to reset values on that edge; pwm low on the following cycle.
- CRS changes during a ramp: the ramp reverses direction at the next step boundary with no extra delay.
- Tach edge detection latency: 3 cycles after the pin edge.

## Configuration
- FAN_STALL_DETECT_EN defined: the tach synchroniser, edge counter, window counter and stall logic are present as above.
- FAN_STALL_DETECT_EN undefined: tach is ignored, stall is tied 0, and no monitor logic is instantiated.

## Structure
- Shared package fan_pkg holds:
  - FAN_MAX_SPEED = 8
  - PWM_SLOTS = 16
  - typedef fan_speed_t (4-bit unsigned)
  - duty width constant

  fan_control and this block both use it.
- One sub-module: fan_tach_monitor (synchroniser, edge counter, window, sticky stall). It is instantiated only under FAN_STALL_DETECT_EN.

## Test plan
Bench parameters: CLK_DIV=2, RAMP_PERIODS=2, STALL_PERIODS=4. One period is 32 cycles; one step is 64 cycles.
- Reset, then Cooler=1, CRS=4 → cur_speed reaches 1,2,3,4 at 64-cycle intervals. at_target rises with 4. Final pwm is high for 16 of every 32 cycles.
- CRS=8 from speed 4 → pwm constantly high once cur_speed=8. CRS=12 gives the same result as 8 (clamp).
- At speed 6, drop Cooler → pwm=0 and cur_speed=0 on the next edge. stall clears.
- Ramping 0→6, CRS changes to 2 at speed 4 → next step goes to 3, then 2. No further change.
- With the stall macro defined: speed 4, no tach edges for 4 periods → stall=1 and stays 1 after tach resumes. With tach toggling every 20 cycles, stall stays 0.
- Assert rst mid-period at speed 6 → the next cycle shows pwm 0, cur_speed 0, at_target 1, stall 0.
